// File: rtl/sd_acq_pkg.sv
// Shared types and constants for the acquisition capture block.
package sd_acq_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned SAMP_W = 16;

    localparam logic [3:0] TAG_HDR = 4'hA;
    localparam logic [3:0] TAG_SMP = 4'h5;
    localparam logic [3:0] TAG_TRL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_TRAILER = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]       tag;
        logic [CNT_W-1:0] payload;
    } word_t;

    // Assemble a tagged FIFO word.
    function automatic word_t make_word(input logic [3:0] tag, input logic [CNT_W-1:0] payload);
        return word_t'({tag, payload});
    endfunction

endpackage

// File: rtl/sd_acq_capture_if.sv
// Reader-side FIFO bus: master is the downstream reader, slave is the capture block.
interface sd_acq_capture_if;
    import sd_acq_pkg::*;

    logic              rd_en;
    logic [WORD_W-1:0] rd_data;
    logic              rd_empty;
    logic              fifo_full;

    modport master (output rd_en, input rd_data, input rd_empty, input fifo_full);
    modport slave  (input rd_en, output rd_data, output rd_empty, output fifo_full);

endinterface

// File: rtl/sd_acq_fifo.sv
// Synchronous FIFO with registered read data and registered full/empty flags.
module sd_acq_fifo
    import sd_acq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              drop_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic              do_wr, do_rd;

    // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
    always_comb begin
        do_rd      = rd_en && !empty;
        do_wr      = wr_en && (!full || do_rd);
        drop_c     = wr_en && full && !rd_en;
        wr_ptr_nxt = do_wr ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_nxt = do_rd ? rd_ptr + PTR_W'(1) : rd_ptr;
    end

    // Pointers, flags and read data register; flags come from the next pointers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            rd_data <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
            full   <= (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]) &&
                      (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);
            if (do_rd) begin
                rd_data <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (do_wr) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/sd_acq_capture.sv
// Acquisition capture: frames ADC samples (header, samples, trailer) into a FIFO while en is high.
// Optional build macro SD_ACQ_CAP_AVG2_EN: average sample pairs into one word.
module sd_acq_capture
    import sd_acq_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              ovf_clr,
    sd_acq_capture_if.slave   bus,
    output logic              overflow,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  window_cnt
);

    state_t            state;
    logic              en_meta, en_sync, en_prev;
    logic              en_rise_c;
    logic [SAMP_W-1:0] samp_cnt;
    logic [SAMP_W-1:0] samp_cnt_inc_c;
    logic              wr_en;
    word_t             wr_data;
    logic              drop_c;

`ifdef SD_ACQ_CAP_AVG2_EN
    logic [DATA_W-1:0] pair_a;
    logic              pair_have;
    logic [DATA_W:0]   pair_sum_c;
    logic [DATA_W-1:0] pair_avg_c;

    // Pair average computed one bit wider, then truncated back to sample width.
    always_comb begin
        pair_sum_c = (DATA_W+1)'(pair_a) + (DATA_W+1)'(adc_data);
        pair_avg_c = DATA_W'(pair_sum_c >> 1);
    end
`endif

    // Two-flop synchroniser plus a delayed copy for edge detection.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            en_meta <= 1'b0;
            en_sync <= 1'b0;
            en_prev <= 1'b0;
        end else begin
            en_meta <= en;
            en_sync <= en_meta;
            en_prev <= en_sync;
        end
    end

    // Edge detect and saturating sample-count increment.
    always_comb begin
        en_rise_c      = en_sync && !en_prev;
        samp_cnt_inc_c = (samp_cnt == {SAMP_W{1'b1}}) ? samp_cnt : samp_cnt + SAMP_W'(1);
    end

    // Frame FSM; the FIFO write strobe and word are registered here.
    // CAPTURE leaves on the synced level so a window closing during HEADER still terminates.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            window_cnt <= '0;
            samp_cnt   <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
`ifdef SD_ACQ_CAP_AVG2_EN
            pair_a     <= '0;
            pair_have  <= 1'b0;
`endif
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en_rise_c) begin
                        state <= ST_HEADER;
                        busy  <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    wr_en      <= 1'b1;
                    wr_data    <= make_word(TAG_HDR, window_cnt);
                    window_cnt <= window_cnt + CNT_W'(1);
                    samp_cnt   <= '0;
`ifdef SD_ACQ_CAP_AVG2_EN
                    pair_have  <= 1'b0;
`endif
                    state      <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (adc_valid) begin
`ifdef SD_ACQ_CAP_AVG2_EN
                        if (pair_have) begin
                            wr_en     <= 1'b1;
                            wr_data   <= make_word(TAG_SMP, CNT_W'(pair_avg_c));
                            samp_cnt  <= samp_cnt_inc_c;
                            pair_have <= 1'b0;
                        end else begin
                            pair_a    <= adc_data;
                            pair_have <= 1'b1;
                        end
`else
                        wr_en    <= 1'b1;
                        wr_data  <= make_word(TAG_SMP, CNT_W'(adc_data));
                        samp_cnt <= samp_cnt_inc_c;
`endif
                    end
                    if (!en_sync) begin
                        state <= ST_TRAILER;
                    end
                end
                ST_TRAILER: begin
                    wr_en      <= 1'b1;
                    wr_data    <= make_word(TAG_TRL, samp_cnt[CNT_W-1:0]);
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    sd_acq_fifo #(
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (bus.rd_en),
        .rd_data (bus.rd_data),
        .empty   (bus.rd_empty),
        .full    (bus.fifo_full),
        .drop_c  (drop_c)
    );

endmodule
